exibe_sequencia: RTL and testbench



---
 rtl/exibe_sequencia_if.sv | 25 ++
 rtl/exibe_sequencia.sv | 119 +++++++++++
 tb/tb_exibe_sequencia.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exibe_sequencia_if.sv
// Playback-side bundle between the sequence player, its sequence ROM and the game control.
// master drives start/limit/ROM data; slave (the player) drives address, LEDs and status.
interface exibe_sequencia_if #(
  parameter int N_END  = 4,
  parameter int N_DADO = 4
);
  logic              iniciar;
  logic [N_END-1:0]  limite;
  logic [N_DADO-1:0] dados;
  logic [N_END-1:0]  endereco;
  logic [N_DADO-1:0] leds;
  logic              exibindo;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, limite, dados,
    input  endereco, leds, exibindo, pronto, db_estado
  );

  modport slave (
    input  iniciar, limite, dados,
    output endereco, leds, exibindo, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia.sv
// Shows the stored sequence 0..limite on the LEDs, T_ACESO lit / T_APAGADO+3 dark per item.
// Starts one cycle after iniciar is sampled in ocioso; no backpressure, pronto pulses once at the end.
module exibe_sequencia #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500,
  parameter int N_END     = 4,
  parameter int N_DADO    = 4
) (
  input  logic               clock,
  input  logic               reset,
  exibe_sequencia_if.slave   bus
);

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CARREGA   = 3'd1,
    ACESO     = 3'd2,
    APAGA     = 3'd3,
    INTERVALO = 3'd4,
    AVANCA    = 3'd5,
    FIM       = 3'd6
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_DADO-1:0] cor_q, cor_d;
  logic [N_END-1:0]  end_q, end_d;
  logic [N_END-1:0]  lim_q, lim_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
      cor_q    <= '0;
      end_q    <= '0;
      lim_q    <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      cor_q    <= cor_d;
      end_q    <= end_d;
      lim_q    <= lim_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    cor_d    = cor_q;
    end_d    = end_q;
    lim_d    = lim_q;
    case (estado_q)
      OCIOSO: begin
        end_d = '0;
        if (bus.iniciar) begin
          lim_d    = bus.limite;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        cor_d    = bus.dados;
        timer_d  = '0;
        estado_d = ACESO;
      end
      ACESO: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(T_ACESO - 1)) begin
          timer_d  = '0;
          estado_d = APAGA;
        end
      end
      APAGA: begin
        timer_d = '0;
        // The last item skips the gap entirely, so endereco never wraps past limite_reg.
        if (end_q == lim_q) estado_d = FIM;
        else                estado_d = INTERVALO;
      end
      INTERVALO: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(T_APAGADO - 1)) begin
          timer_d  = '0;
          estado_d = AVANCA;
        end
      end
      AVANCA: begin
        end_d    = end_q + 1'b1;
        estado_d = CARREGA;
      end
      FIM: begin
        end_d    = '0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    bus.leds      = '0;
    bus.exibindo  = 1'b0;
    bus.pronto    = 1'b0;
    bus.db_estado = 4'b1001;
    case (estado_q)
      OCIOSO:    bus.db_estado = 4'd0;
      CARREGA:   begin bus.db_estado = 4'd1; bus.exibindo = 1'b1; end
      ACESO:     begin bus.db_estado = 4'd2; bus.exibindo = 1'b1; bus.leds = cor_q; end
      APAGA:     begin bus.db_estado = 4'd3; bus.exibindo = 1'b1; end
      INTERVALO: begin bus.db_estado = 4'd4; bus.exibindo = 1'b1; end
      AVANCA:    begin bus.db_estado = 4'd5; bus.exibindo = 1'b1; end
      FIM:       begin bus.db_estado = 4'd6; bus.pronto = 1'b1; end
      default:   bus.db_estado = 4'b1001;
    endcase
  end

  assign bus.endereco = end_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia with T_ACESO=4, T_APAGADO=2.
// Expected items and fim timing are queued at stimulus time and popped by a negedge monitor.
module tb_exibe_sequencia;

  localparam int TA = 4;
  localparam int TP = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exibe_sequencia_if #(.N_END(4), .N_DADO(4)) bus ();

  exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .N_END(4), .N_DADO(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] mem [16];
  assign bus.dados = mem[bus.endereco];

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] cor;
  } item_t;

  item_t item_q[$];
  int    fim_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int lim);
    for (int i = 0; i <= lim; i++) begin
      logic [3:0] a;
      a = i[3:0];
      item_q.push_back({a, mem[a]});
    end
    fim_q.push_back((lim + 1) * (TA + 2) + lim * (TP + 1));
  endtask

  task automatic play(input int lim);
    bus.limite = lim[3:0];
    push_exp(lim);
    bus.iniciar = 1'b1;
    @(posedge clock); #1;
    bus.iniciar = 1'b0;
  endtask

  task automatic wait_db(input logic [3:0] code, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clock); #1;
      if (bus.db_estado == code) hit = 1'b1;
    end
    if (!hit) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int peak);
    bit hit;
    hit  = 1'b0;
    peak = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clock); #1;
      if (int'(bus.endereco) > peak) peak = int'(bus.endereco);
      if (bus.db_estado == 4'd0) hit = 1'b1;
    end
    if (!hit) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: per-item content/duration, dark-gap length and carrega-to-fim latency.
  logic [3:0] prev_st  = 4'd0;
  logic [3:0] cur_cor  = 4'd0;
  bit         in_play  = 1'b0;
  bit         gap_on   = 1'b0;
  int         cyc      = 0;
  int         run_len  = 0;
  int         gap_len  = 0;

  always @(negedge clock) begin
    logic [3:0] st;
    item_t      it;
    int         exp_cyc;
    st = bus.db_estado;
    if (reset) begin
      item_q.delete();
      fim_q.delete();
      in_play = 1'b0;
      gap_on  = 1'b0;
      prev_st = 4'd0;
    end else begin
      if (st == 4'd1 && !in_play) begin
        in_play = 1'b1;
        cyc     = 0;
      end else if (in_play) begin
        cyc++;
      end
      if (st == 4'd2 && prev_st != 4'd2) begin
        if (gap_on) check("gap_len", gap_len, TP + 3);
        gap_on = 1'b0;
        if (item_q.size() == 0) begin
          check("unexpected_item", 32'd1, 32'd0);
          cur_cor = 4'd0;
        end else begin
          it = item_q.pop_front();
          check("item_addr", bus.endereco, it.addr);
          cur_cor = it.cor;
        end
        run_len = 1;
      end else if (st == 4'd2) begin
        run_len++;
      end
      if (st == 4'd2) check("leds_lit", bus.leds, cur_cor);
      if (st != 4'd2 && prev_st == 4'd2) begin
        check("lit_len", run_len, TA);
        gap_on  = 1'b1;
        gap_len = 0;
      end
      if (gap_on && st != 4'd2) gap_len++;
      if (st == 4'd6) begin
        if (fim_q.size() == 0) begin
          check("unexpected_pronto", 32'd1, 32'd0);
        end else begin
          exp_cyc = fim_q.pop_front();
          check("fim_latency", cyc, exp_cyc);
        end
        check("pronto_in_fim", bus.pronto, 1'b1);
        in_play = 1'b0;
        gap_on  = 1'b0;
      end
      prev_st = st;
    end
  end

  initial begin
    int peak;
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;

    // Reset with random inputs
    reset = 1'b1;
    repeat (2) begin
      bus.iniciar = 1'($urandom_range(0, 1));
      bus.limite  = 4'($urandom_range(0, 15));
      @(posedge clock); #1;
    end
    check("rst_leds", bus.leds, 4'd0);
    check("rst_end", bus.endereco, 4'd0);
    check("rst_exib", bus.exibindo, 1'b0);
    check("rst_pronto", bus.pronto, 1'b0);
    check("rst_db", bus.db_estado, 4'd0);
    bus.iniciar = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single item, cycle-exact
    mem[0] = 4'b0010;
    bus.limite = 4'd0;
    push_exp(0);
    bus.iniciar = 1'b1;
    @(posedge clock); #1;
    bus.iniciar = 1'b0;
    check("one_carrega", bus.db_estado, 4'd1);
    check("one_exib", bus.exibindo, 1'b1);
    for (int i = 0; i < TA; i++) begin
      @(posedge clock); #1;
      check("one_leds", bus.leds, 4'b0010);
    end
    @(posedge clock); #1;
    check("one_apaga", bus.db_estado, 4'd3);
    check("one_dark", bus.leds, 4'd0);
    @(posedge clock); #1;
    check("one_pronto", bus.pronto, 1'b1);
    check("one_fim", bus.db_estado, 4'd6);
    @(posedge clock); #1;
    check("one_ocioso", bus.db_estado, 4'd0);
    check("one_end0", bus.endereco, 4'd0);
    check("one_pronto_off", bus.pronto, 1'b0);

    // Four items
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
    play(3);
    wait_idle(100, peak);
    check("four_peak", peak, 3);

    // Ignored iniciar / limite during playback
    play(2);
    for (int i = 0; i < 8; i++) begin
      bus.iniciar = ~bus.iniciar;
      bus.limite  = 4'd7;
      @(posedge clock); #1;
    end
    bus.iniciar = 1'b0;
    wait_idle(100, peak);
    check("ign_peak", peak, 2);
    @(posedge clock); #1;
    check("ign_stay_idle", bus.db_estado, 4'd0);

    // iniciar held high through fim restarts immediately with the then-current limite
    bus.limite = 4'd2;
    push_exp(2);
    bus.iniciar = 1'b1;
    @(posedge clock); #1;
    bus.limite = 4'd1;
    push_exp(1);
    wait_db(4'd6, 100, "held_fim_timeout");
    @(posedge clock); #1;
    check("held_ocioso", bus.db_estado, 4'd0);
    @(posedge clock); #1;
    check("held_restart", bus.db_estado, 4'd1);
    bus.iniciar = 1'b0;
    wait_idle(100, peak);
    check("held_peak", peak, 1);

    // Abort with reset during aceso of item 1
    play(3);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(posedge clock); #1;
        if (bus.db_estado == 4'd2 && bus.endereco == 4'd1) hit = 1'b1;
      end
      if (!hit) check("abort_timeout", 32'd0, 32'd1);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_db", bus.db_estado, 4'd0);
    check("abort_leds", bus.leds, 4'd0);
    check("abort_end", bus.endereco, 4'd0);
    check("abort_exib", bus.exibindo, 1'b0);
    reset = 1'b0;
    begin
      int pr;
      pr = 0;
      repeat (40) begin
        @(posedge clock); #1;
        if (bus.pronto) pr++;
      end
      check("abort_no_pronto", pr, 0);
    end

    // Full length, 16 items
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
    play(15);
    wait_idle(400, peak);
    check("full_peak", peak, 15);

    // Blank item still takes full timing
    mem[0] = 4'b0000; mem[1] = 4'b0100;
    play(1);
    wait_idle(100, peak);

    @(posedge clock); #1;
    check("sb_items_left", item_q.size(), 0);
    check("sb_fim_left", fim_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
